// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module : rv32i_pkg
// Brief  : Shared RV32I encoding types, field positions and loader states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_format_e;

  // Field LSB positions, identical to the decode-stage parser.
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_encoder_if.sv
// ============================================================================
// Module : instruction_encoder_if
// Brief  : Field-beat input, IMEM write port and status of the loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instruction_encoder_if #(
  parameter int IMEM_ADDR_W = 10
);
  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_format;
  logic [6:0]             in_opcode;
  logic [4:0]             in_rd;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [2:0]             in_funct3;
  logic [6:0]             in_funct7;
  logic [31:0]            in_imm;
  logic                   in_last;
  logic                   imem_we;
  logic                   imem_ready;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_wdata;
  logic                   busy;
  logic                   done;
  logic                   err_illegal;
  logic                   err_wrap;

  modport master (
    output start, in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done,
           err_illegal, err_wrap
  );

  modport slave (
    input  start, in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done,
           err_illegal, err_wrap
  );

endinterface

`default_nettype wire

// File: rtl/rv32i_field_packer.sv
// ============================================================================
// Module : rv32i_field_packer
// Brief  : Combinational RV32I field packer: fields + format -> word, illegal.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_field_packer
  import rv32i_pkg::*;
(
  input  wire logic [2:0]  i_format,
  input  wire logic [6:0]  i_opcode,
  input  wire logic [4:0]  i_rd,
  input  wire logic [4:0]  i_rs1,
  input  wire logic [4:0]  i_rs2,
  input  wire logic [2:0]  i_funct3,
  input  wire logic [6:0]  i_funct7,
  input  wire logic [31:0] i_imm,
  output logic      [31:0] o_word,
  output logic             o_illegal
);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    o_word[OPCODE_LSB +: 7] = i_opcode;
    case (instr_format_e'(i_format))
      FMT_R: begin
        o_word[RD_LSB     +: 5] = i_rd;
        o_word[FUNCT3_LSB +: 3] = i_funct3;
        o_word[RS1_LSB    +: 5] = i_rs1;
        o_word[RS2_LSB    +: 5] = i_rs2;
        o_word[FUNCT7_LSB +: 7] = i_funct7;
      end
      FMT_I: begin
        o_word[RD_LSB     +: 5] = i_rd;
        o_word[FUNCT3_LSB +: 3] = i_funct3;
        o_word[RS1_LSB    +: 5] = i_rs1;
        o_word[31:20]           = i_imm[11:0];
      end
      FMT_S: begin
        o_word[RD_LSB     +: 5] = i_imm[4:0];
        o_word[FUNCT3_LSB +: 3] = i_funct3;
        o_word[RS1_LSB    +: 5] = i_rs1;
        o_word[RS2_LSB    +: 5] = i_rs2;
        o_word[FUNCT7_LSB +: 7] = i_imm[11:5];
      end
      FMT_B: begin
        o_word[RD_LSB     +: 5] = {i_imm[4:1], i_imm[11]};
        o_word[FUNCT3_LSB +: 3] = i_funct3;
        o_word[RS1_LSB    +: 5] = i_rs1;
        o_word[RS2_LSB    +: 5] = i_rs2;
        o_word[FUNCT7_LSB +: 7] = {i_imm[12], i_imm[10:5]};
        o_illegal               = i_imm[0];
      end
      FMT_U: begin
        o_word[RD_LSB +: 5] = i_rd;
        o_word[31:12]       = i_imm[31:12];
      end
      FMT_J: begin
        o_word[RD_LSB +: 5] = i_rd;
        o_word[31:12]       = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12]};
        o_illegal           = i_imm[0];
      end
      default: begin
        // Unknown format still occupies its IMEM slot, as a NOP.
        o_word    = INSTR_NOP;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instruction_encoder.sv
// ============================================================================
// Module : instruction_encoder
// Brief  : Packs RV32I field beats into words and streams them into IMEM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_encoder
  import rv32i_pkg::*;
#(
  parameter int                     IMEM_ADDR_W = 10,
  parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR   = '0
) (
  input wire logic               clk,
  input wire logic               rst_n,
  instruction_encoder_if.slave   bus
);

  loader_state_e          r_state;
  loader_state_e          w_state_nxt;
  logic                   r_we;
  logic [31:0]            r_wdata;
  logic [IMEM_ADDR_W-1:0] r_addr;
  logic                   r_err_illegal;
  logic                   r_err_wrap;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_write;
  logic                   w_start;
  logic                   w_busy;
  logic                   w_done;
  logic [31:0]            w_word;
  logic                   w_illegal;

  rv32i_field_packer u_packer (
    .i_format  (bus.in_format),
    .i_opcode  (bus.in_opcode),
    .i_rd      (bus.in_rd),
    .i_rs1     (bus.in_rs1),
    .i_rs2     (bus.in_rs2),
    .i_funct3  (bus.in_funct3),
    .i_funct7  (bus.in_funct7),
    .i_imm     (bus.in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // The output register may be refilled in the same cycle it is drained.
  assign w_in_ready = (r_state == LOAD) && (!r_we || bus.imem_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_write    = r_we && bus.imem_ready;
  assign w_start    = (r_state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = LOAD;
      end
      LOAD:  if (w_accept && bus.in_last) w_state_nxt = DRAIN;
      DRAIN: if (!r_we) w_state_nxt = DONE;
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= 1'b1;
      r_wdata <= w_word;
    end else if (w_write) begin
      r_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= BASE_ADDR;
      r_err_illegal <= 1'b0;
      r_err_wrap    <= 1'b0;
    end else if (w_start) begin
      r_addr        <= BASE_ADDR;
      r_err_illegal <= 1'b0;
      r_err_wrap    <= 1'b0;
    end else begin
      if (w_write) r_addr <= r_addr + IMEM_ADDR_W'(1);
      if (w_accept && w_illegal) r_err_illegal <= 1'b1;
      // Wrap is reported but never blocks the write.
      if (w_write && (&r_addr)) r_err_wrap <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.imem_we     = r_we;
  assign bus.imem_addr   = r_addr;
  assign bus.imem_wdata  = r_wdata;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.err_illegal = r_err_illegal;
  assign bus.err_wrap    = r_err_wrap;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
// Module : tb_instruction_encoder
// Brief  : Randomised self-checking bench with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_encoder;

  localparam int            AW   = 10;
  localparam logic [AW-1:0] BASE = 10'h010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_encoder_if #(.IMEM_ADDR_W(AW)) bus ();

  instruction_encoder #(.IMEM_ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int ready_pct = 100;
  int stall_cnt = 0;
  int done_cnt  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t wlog[$];

  // Reference model state: session phase 0=idle 1=loading 2=draining 3=finished
  int            m_phase = 0;
  logic [31:0]   m_q[$];
  logic [AW-1:0] m_addr  = BASE;
  bit            m_ill   = 1'b0;
  bit            m_wrap  = 1'b0;

  int            d_fmt[8];
  logic [6:0]    d_op[8];
  logic [4:0]    d_rd[8], d_rs1[8], d_rs2[8];
  logic [2:0]    d_f3[8];
  logic [6:0]    d_f7[8];
  logic [31:0]   d_imm[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  // Returns {illegal, word}, built from the format table by shifting fields into place.
  function automatic logic [32:0] model_enc(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] regs;
    bit          ill;
    ill  = 1'b0;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (fmt)
      0: w = (32'(f7) << 25) | regs | (32'(rd) << 7);
      1: w = (fld(imm, 11, 0) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      2: w = (fld(imm, 11, 5) << 25) | regs | (fld(imm, 4, 0) << 7);
      3: begin
        w   = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | regs |
              (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
        ill = imm[0];
      end
      4: w = (fld(imm, 31, 12) << 12) | (32'(rd) << 7) | 32'(op);
      5: begin
        w   = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
              (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
        ill = imm[0];
      end
      default: begin
        w   = 32'h0000_0013;
        ill = 1'b1;
      end
    endcase
    return {ill, w};
  endfunction

  // Compare process: checks every cycle, then advances the model to the next edge.
  initial begin
    bit          exp_we, exp_ir, hs, acc;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0;
        m_q.delete();
        m_addr  = BASE;
        m_ill   = 1'b0;
        m_wrap  = 1'b0;
      end
      exp_we = (m_q.size() != 0);
      exp_ir = (m_phase == 1) && (!exp_we || bus.imem_ready);
      chk("imem_we",     32'(bus.imem_we),     32'(exp_we));
      chk("in_ready",    32'(bus.in_ready),    32'(exp_ir));
      chk("busy",        32'(bus.busy),        32'(m_phase != 0));
      chk("done",        32'(bus.done),        32'(m_phase == 3));
      chk("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
      chk("err_wrap",    32'(bus.err_wrap),    32'(m_wrap));
      chk("imem_addr",   32'(bus.imem_addr),   32'(m_addr));
      if (exp_we) chk("imem_wdata", bus.imem_wdata, m_q[0]);
      if (bus.imem_we && bus.imem_ready) wlog.push_back('{bus.imem_addr, bus.imem_wdata});
      if (bus.done) done_cnt++;
      if (rst_n) begin
        hs  = exp_we && bus.imem_ready;
        acc = bus.in_valid && exp_ir;
        if (hs) begin
          void'(m_q.pop_front());
          if (m_addr == {AW{1'b1}}) m_wrap = 1'b1;
          m_addr = m_addr + 1;
        end
        if (acc) begin
          e = model_enc(int'(bus.in_format), bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                        bus.in_funct3, bus.in_funct7, bus.in_imm);
          m_q.push_back(e[31:0]);
          if (e[32]) m_ill = 1'b1;
        end
        case (m_phase)
          0: if (bus.start) begin
               m_phase = 1;
               m_addr  = BASE;
               m_ill   = 1'b0;
               m_wrap  = 1'b0;
             end
          1: if (acc && bus.in_last) m_phase = 2;
          2: if (!exp_we) m_phase = 3;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // IMEM back-pressure generator.
  initial begin
    bus.imem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        bus.imem_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.imem_ready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input int i, input int fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    d_fmt[i] = fmt; d_op[i] = op; d_rd[i] = rd; d_rs1[i] = rs1; d_rs2[i] = rs2;
    d_f3[i] = f3; d_f7[i] = f7; d_imm[i] = imm;
  endtask

  task automatic run_session(input int n, input bit directed, input int vpct, input int stall_at);
    int  i, guard, d0;
    bit  acc, fresh;
    logic [31:0] imm;
    d0 = done_cnt;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy",       32'(bus.busy),        32'h1);
    chk("start_clears_ill", 32'(bus.err_illegal), 32'h0);
    chk("start_clears_wrp", 32'(bus.err_wrap),    32'h0);
    i = 0; guard = 0; fresh = 1'b1;
    while (i < n) begin
      if (fresh) begin
        if (directed) begin
          bus.in_format = 3'(d_fmt[i]); bus.in_opcode = d_op[i]; bus.in_rd = d_rd[i];
          bus.in_rs1 = d_rs1[i]; bus.in_rs2 = d_rs2[i]; bus.in_funct3 = d_f3[i];
          bus.in_funct7 = d_f7[i]; bus.in_imm = d_imm[i];
        end else begin
          bus.in_format = ($urandom_range(9) < 9) ? 3'($urandom_range(5)) : 3'($urandom_range(7, 6));
          bus.in_opcode = 7'($urandom); bus.in_rd = 5'($urandom); bus.in_rs1 = 5'($urandom);
          bus.in_rs2 = 5'($urandom); bus.in_funct3 = 3'($urandom); bus.in_funct7 = 7'($urandom);
          imm = $urandom;
          if ($urandom_range(9) != 0) imm[0] = 1'b0;
          bus.in_imm = imm;
        end
        bus.in_last = (i == n - 1);
        if (i == stall_at) stall_cnt = 3;
        fresh = 1'b0;
      end
      bus.in_valid = ($urandom_range(99) < vpct);
      bus.start    = !directed && ($urandom_range(9) == 0);
      @(negedge clk);
      #1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        i++; guard = 0; fresh = 1'b1;
      end else if (++guard > 200) begin
        n_cmp++; n_mis++;
        $display("FAIL beat_timeout: beat %0d not accepted, required within 200 cycles", i);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 300) begin
      tick();
      guard++;
    end
    tick();
    tick();
    chk("done_pulses", 32'(done_cnt - d0), 32'h1);
    chk("busy_after",  32'(bus.busy),      32'h0);
  endtask

  initial begin
    logic [32:0] e;
    int          nlog;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_format = '0;
    bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    repeat (3) tick();
    chk("rst_we",       32'(bus.imem_we),     32'h0);
    chk("rst_in_ready", 32'(bus.in_ready),    32'h0);
    chk("rst_busy",     32'(bus.busy),        32'h0);
    chk("rst_done",     32'(bus.done),        32'h0);
    chk("rst_err_ill",  32'(bus.err_illegal), 32'h0);
    chk("rst_err_wrap", 32'(bus.err_wrap),    32'h0);
    chk("rst_addr",     32'(bus.imem_addr),   32'h010);
    chk("rst_wdata",    bus.imem_wdata,       32'h0);
    rst_n = 1'b1;

    e = model_enc(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);         chk("model_add",  e[31:0], 32'h002081B3);
    e = model_enc(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF); chk("model_addi", e[31:0], 32'hFFF00093);
    e = model_enc(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);         chk("model_beq",  e[31:0], 32'h00208463);
    e = model_enc(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);       chk("model_jal",  e[31:0], 32'h001000EF);

    set_dir(0, 0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    set_dir(1, 1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    set_dir(2, 3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    wlog.delete();
    run_session(3, 1'b1, 100, -1);
    nlog = wlog.size();
    chk("s1_nwrites", 32'(nlog), 32'd3);
    if (nlog >= 3) begin
      chk("s1_addr0", 32'(wlog[0].addr), 32'h010); chk("s1_data0", wlog[0].data, 32'h002081B3);
      chk("s1_addr1", 32'(wlog[1].addr), 32'h011); chk("s1_data1", wlog[1].data, 32'hFFF00093);
      chk("s1_addr2", 32'(wlog[2].addr), 32'h012); chk("s1_data2", wlog[2].data, 32'h00208463);
    end

    set_dir(0, 5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    set_dir(1, 7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    set_dir(2, 3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5);
    set_dir(3, 0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    set_dir(4, 1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    wlog.delete();
    run_session(5, 1'b1, 100, 2);
    chk("s2_err_illegal", 32'(bus.err_illegal), 32'h1);
    if (wlog.size() >= 2) begin
      chk("s2_data_jal", wlog[0].data, 32'h001000EF);
      chk("s2_data_nop", wlog[1].data, 32'h00000013);
      chk("s2_addr_nop", 32'(wlog[1].addr), 32'h011);
    end else begin
      chk("s2_nwrites", 32'(wlog.size()), 32'd5);
    end

    ready_pct = 85;
    wlog.delete();
    run_session(1020, 1'b0, 90, -1);
    chk("wrap_flag", 32'(bus.err_wrap), 32'h1);
    if (wlog.size() > 1008) begin
      chk("wrap_addr_last", 32'(wlog[1007].addr), 32'h3FF);
      chk("wrap_addr_zero", 32'(wlog[1008].addr), 32'h000);
    end else begin
      chk("wrap_nwrites", 32'(wlog.size()), 32'd1020);
    end

    repeat (6) begin
      ready_pct = $urandom_range(30, 100);
      run_session($urandom_range(1, 40), 1'b0, $urandom_range(30, 100), -1);
    end

    ready_pct = 0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_format = 3'd0; bus.in_opcode = 7'h33; bus.in_rd = 5'd3;
    bus.in_rs1    = 5'd1; bus.in_rs2    = 5'd2;  bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0; bus.in_imm    = 32'd0; bus.in_last = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 10 && !bus.imem_we; k++) tick();
    chk("pre_rst_we", 32'(bus.imem_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we",       32'(bus.imem_we),     32'h0);
    chk("arst_in_ready", 32'(bus.in_ready),    32'h0);
    chk("arst_busy",     32'(bus.busy),        32'h0);
    chk("arst_err_ill",  32'(bus.err_illegal), 32'h0);
    chk("arst_addr",     32'(bus.imem_addr),   32'h010);
    chk("arst_wdata",    bus.imem_wdata,       32'h0);
    tick();
    rst_n     = 1'b1;
    ready_pct = 100;
    nlog      = wlog.size();
    repeat (10) tick();
    chk("no_write_after_rst", 32'(wlog.size() - nlog), 32'h0);
    bus.in_valid = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
